// File: rtl/bidir_duplex_pkg.sv
// rtl/bidir_duplex_pkg.sv - shared encodings and pattern step helpers for bidir_duplex_engine
package bidir_duplex_pkg;

   localparam logic [1:0] MODE_LOOP    = 2'd0;
   localparam logic [1:0] MODE_GEN     = 2'd1;
   localparam logic [1:0] MODE_CHECK   = 2'd2;
   localparam logic [1:0] MODE_LOOPCHK = 2'd3;

   localparam logic [1:0] PAT_CNT   = 2'd0;
   localparam logic [1:0] PAT_LFSR  = 2'd1;
   localparam logic [1:0] PAT_WALK  = 2'd2;
   localparam logic [1:0] PAT_FIXED = 2'd3;

   localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;
   localparam logic [63:0] LFSR_TAPS_64 = 64'hD800000000000000;

   // Low-w-bit mask on the 64-bit carrier used by the helpers below.
   function automatic logic [63:0] width_mask(input int unsigned w);
      logic [63:0] m;
      if (w >= 64) m = '1;
      else         m = (64'd1 << w) - 64'd1;
      return m;
   endfunction

   // One generator step; words travel zero-extended in 64 bits so one
   // function serves both pipe widths.
   function automatic logic [63:0] pattern_next(input logic [1:0]  sel,
                                                input logic [63:0] word,
                                                input int unsigned w);
      logic [63:0] m;
      logic [63:0] taps;
      logic [63:0] nxt;
      m    = width_mask(w);
      taps = (w == 64) ? LFSR_TAPS_64 : {32'd0, LFSR_TAPS_32};
      nxt  = '0;
      case (sel)
         PAT_CNT:  nxt = word + 64'd1;
         PAT_LFSR: nxt = word[0] ? (((word & m) >> 1) ^ taps) : ((word & m) >> 1);
         PAT_WALK: nxt = (word << 1) | ((word >> (w - 1)) & 64'd1);
         default:  nxt = word;
      endcase
      return nxt & m;
   endfunction

   // Start word after a load: walking-one always begins at bit 0 and an
   // all-zero LFSR state would lock up, so it is replaced by 1.
   function automatic logic [63:0] pattern_load(input logic [1:0]  sel,
                                                input logic [63:0] seed,
                                                input int unsigned w);
      logic [63:0] s;
      s = seed & width_mask(w);
      if (sel == PAT_WALK)                   s = 64'd1;
      else if (sel == PAT_LFSR && s == '0)   s = 64'd1;
      return s;
   endfunction

endpackage

// File: rtl/bidir_duplex_pattern_gen.sv
// rtl/bidir_duplex_pattern_gen.sv - shared pattern generator with load and advance
module pattern_gen #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              advance,
   input  logic [1:0]        sel,
   input  logic [DATA_W-1:0] seed,
   output logic [DATA_W-1:0] word
);
   import bidir_duplex_pkg::*;

   logic [DATA_W-1:0] word_q;
   logic              loaded_q;
   logic [DATA_W-1:0] start_word;
   logic [DATA_W-1:0] cur_word;

   // Until the first advance after reset or load, the word is derived from
   // the live seed, so the async reset never has to capture an input value.
   assign start_word = DATA_W'(pattern_load(sel, 64'(seed), DATA_W));
   assign cur_word   = (sel == PAT_FIXED) ? seed : (loaded_q ? word_q : start_word);
   assign word       = cur_word;

   // Step state; a load in the same cycle as an advance wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q   <= '0;
         loaded_q <= 1'b0;
      end else if (load) begin
         loaded_q <= 1'b0;
      end else if (advance) begin
         word_q   <= DATA_W'(pattern_next(sel, 64'(cur_word), DATA_W));
         loaded_q <= 1'b1;
      end
   end

endmodule

// File: rtl/bidir_duplex_engine.sv
// rtl/bidir_duplex_engine.sv - loopback FIFO with pattern generate/check, timer and statistics
module bidir_duplex_engine #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               mode,
   input  logic [1:0]               pattern_sel,
   input  logic [DATA_W-1:0]        pattern_seed,
   input  logic                     reset_pattern,
   input  logic                     clear_stats,
   input  logic                     start_timer,
   input  logic                     stop_timer,
   input  logic                     in_write,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     out_read,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic                     underflow,
   output logic                     timer_on,
   output logic [63:0]              clk_counts,
   output logic [CNT_W-1:0]         error_count,
   output logic [CNT_W-1:0]         first_err_index,
   output logic [CNT_W-1:0]         words_in,
   output logic [CNT_W-1:0]         words_out
);
   import bidir_duplex_pkg::*;

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [DATA_W-1:0] head_word;
   logic [DATA_W-1:0] gen_word;
   logic [DATA_W-1:0] chk_data;
   logic              fifo_mode;
   logic              push;
   logic              pop;
   logic              ovf_ev;
   logic              unf_ev;
   logic              serve_gen;
   logic              take_chk;
   logic              chk_en;
   logic              mismatch;
   logic              gen_adv;
   logic              win_ev;
   logic              wout_ev;
   logic [CNT_W-1:0]  chk_idx;
   logic              err_seen;

   assign full      = (fifo_level == FULL_LVL);
   assign empty     = (fifo_level == '0);
   assign head_word = mem[rd_ptr];

   assign fifo_mode = (mode == MODE_LOOP) || (mode == MODE_LOOPCHK);
   assign pop       = fifo_mode && out_read && !empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign push      = fifo_mode && in_write && (!full || pop);
   assign ovf_ev    = fifo_mode && in_write && full && !out_read;
   assign unf_ev    = out_read && ((fifo_mode && empty) || (mode == MODE_CHECK));
   assign serve_gen = (mode == MODE_GEN) && out_read;
   assign take_chk  = (mode == MODE_CHECK) && in_write;
   assign chk_en    = take_chk || ((mode == MODE_LOOPCHK) && pop);
   assign chk_data  = take_chk ? in_data : head_word;
   assign mismatch  = chk_en && (chk_data != gen_word);
   assign gen_adv   = serve_gen || chk_en;
   assign win_ev    = push || take_chk;
   assign wout_ev   = pop || serve_gen;

   pattern_gen #(.DATA_W(DATA_W)) u_gen (
      .clk     (clk),
      .rst     (rst),
      .load    (reset_pattern),
      .advance (gen_adv),
      .sel     (pattern_sel),
      .seed    (pattern_seed),
      .word    (gen_word)
   );

   // Pipe-out word: generator in generate mode, FIFO head in loop modes, else zero.
   always_comb begin
      out_data = '0;
      if (mode == MODE_GEN)         out_data = gen_word;
      else if (fifo_mode && !empty) out_data = head_word;
   end

   // FIFO storage, left unreset so it maps onto a dual-port RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
            2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Sticky overflow/underflow flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear_stats) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_ev) overflow  <= 1'b1;
         if (unf_ev) underflow <= 1'b1;
      end
   end

   // Saturating word and error counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         words_in    <= '0;
         words_out   <= '0;
         error_count <= '0;
      end else if (clear_stats) begin
         words_in    <= '0;
         words_out   <= '0;
         error_count <= '0;
      end else begin
         if (win_ev && words_in != '1)       words_in    <= words_in + CNT_W'(1);
         if (wout_ev && words_out != '1)     words_out   <= words_out + CNT_W'(1);
         if (mismatch && error_count != '1)  error_count <= error_count + CNT_W'(1);
      end
   end

   // Checked-word index and capture of the first mismatch position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_idx         <= '0;
         err_seen        <= 1'b0;
         first_err_index <= '1;
      end else begin
         if (clear_stats) begin
            err_seen        <= 1'b0;
            first_err_index <= '1;
         end else if (mismatch && !err_seen) begin
            err_seen        <= 1'b1;
            first_err_index <= chk_idx;
         end
         if (clear_stats || reset_pattern)   chk_idx <= '0;
         else if (chk_en && chk_idx != '1)   chk_idx <= chk_idx + CNT_W'(1);
      end
   end

   // Throughput timer: start counts its own cycle, stop's cycle is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_on   <= 1'b0;
         clk_counts <= '0;
      end else begin
         if (stop_timer)       timer_on <= 1'b0;
         else if (start_timer) timer_on <= 1'b1;
         if (clear_stats)                                     clk_counts <= '0;
         else if ((timer_on || start_timer) && !stop_timer)   clk_counts <= clk_counts + 64'd1;
      end
   end

endmodule

// File: tb/tb_bidir_duplex_engine.sv
// tb/tb_bidir_duplex_engine.sv - self-checking bench for bidir_duplex_engine
module tb_bidir_duplex_engine;

   localparam logic [63:0] TAPS32 = 64'h0000_0000_8020_0003;
   localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic [1:0]  pattern_sel;
   logic [63:0] pattern_seed;
   logic        reset_pattern;
   logic        clear_stats;
   logic        start_timer;
   logic        stop_timer;
   logic        in_write;
   logic [63:0] in_data;
   logic        out_read;

   logic [31:0] o32;
   logic [4:0]  lvl32;
   logic        full32, empty32, ovf32, unf32, ton32;
   logic [63:0] clk32;
   logic [31:0] err32, fei32, win32, wout32;

   logic [63:0] o64;
   logic [4:0]  lvl64;
   logic        full64, empty64, ovf64, unf64, ton64;
   logic [63:0] clk64;
   logic [31:0] err64, fei64, win64, wout64;

   int pass_cnt;
   int total_cnt;

   bidir_duplex_engine #(.DATA_W(32), .DEPTH(16), .CNT_W(32)) u32 (
      .clk(clk), .rst(rst), .mode(mode), .pattern_sel(pattern_sel),
      .pattern_seed(pattern_seed[31:0]), .reset_pattern(reset_pattern),
      .clear_stats(clear_stats), .start_timer(start_timer), .stop_timer(stop_timer),
      .in_write(in_write), .in_data(in_data[31:0]), .out_read(out_read),
      .out_data(o32), .fifo_level(lvl32), .full(full32), .empty(empty32),
      .overflow(ovf32), .underflow(unf32), .timer_on(ton32), .clk_counts(clk32),
      .error_count(err32), .first_err_index(fei32), .words_in(win32), .words_out(wout32)
   );

   bidir_duplex_engine #(.DATA_W(64), .DEPTH(16), .CNT_W(32)) u64 (
      .clk(clk), .rst(rst), .mode(mode), .pattern_sel(pattern_sel),
      .pattern_seed(pattern_seed), .reset_pattern(reset_pattern),
      .clear_stats(clear_stats), .start_timer(start_timer), .stop_timer(stop_timer),
      .in_write(in_write), .in_data(in_data), .out_read(out_read),
      .out_data(o64), .fifo_level(lvl64), .full(full64), .empty(empty64),
      .overflow(ovf64), .underflow(unf64), .timer_on(ton64), .clk_counts(clk64),
      .error_count(err64), .first_err_index(fei64), .words_in(win64), .words_out(wout64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic [31:0] exp_data;
      logic [31:0] exp_wout;
   } gen_vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_reload();
      reset_pattern = 1'b1;
      clear_stats   = 1'b1;
      tick();
      reset_pattern = 1'b0;
      clear_stats   = 1'b0;
   endtask

   // k-th word of a pattern sequence, computed from its definition.
   function automatic logic [63:0] ref_word(input logic [1:0] sel, input logic [63:0] seed,
                                            input int k, input int w);
      logic [63:0] m;
      logic [63:0] x;
      m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      case (sel)
         2'd0: x = (seed + 64'(k)) & m;
         2'd1: begin
            x = seed & m;
            if (x == 64'd0) x = 64'd1;
            for (int i = 0; i < k; i++)
               x = x[0] ? ((x >> 1) ^ ((w == 64) ? TAPS64 : TAPS32)) : (x >> 1);
         end
         2'd2: x = 64'd1 << (k % w);
         default: x = seed & m;
      endcase
      return x;
   endfunction

   initial begin
      gen_vec_t    gv [5];
      logic [31:0] q [$];
      logic [63:0] seed;
      logic [31:0] d;
      logic        w_, r_;
      bit          pop_ok, push_ok, m_ovf, m_unf;
      int          push_j, k, m_err, m_first, m_win, m_wout;

      pass_cnt = 0;
      total_cnt = 0;
      rst = 1'b1; mode = 2'd0; pattern_sel = 2'd0; pattern_seed = 64'd0;
      reset_pattern = 0; clear_stats = 0; start_timer = 0; stop_timer = 0;
      in_write = 0; in_data = 64'd0; out_read = 0;
      tick(); tick();
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_level", 64'(lvl32), 64'd0);
      chk("rst_empty", 64'(empty32), 64'd1);
      chk("rst_full", 64'(full32), 64'd0);
      chk("rst_flags", 64'({ovf32, unf32, ton32}), 64'd0);
      chk("rst_clk", clk32, 64'd0);
      chk("rst_err", 64'(err32), 64'd0);
      chk("rst_fei", 64'(fei32), 64'hFFFF_FFFF);
      chk("rst_words", 64'({win32, wout32}), 64'd0);
      chk("rst_out", 64'(o32), 64'd0);
      tick();

      // Test 1: loopback fill, overflow, ordered drain, underflow corners
      for (int i = 0; i < 16; i++) begin
         in_write = 1; in_data = 64'(i);
         tick();
         if (i == 0) chk("t1_first_empty", 64'(empty32), 64'd0);
      end
      chk("t1_full", 64'(full32), 64'd1);
      chk("t1_level16", 64'(lvl32), 64'd16);
      in_data = 64'd99;
      tick();
      in_write = 0;
      chk("t1_overflow", 64'(ovf32), 64'd1);
      chk("t1_words_in", 64'(win32), 64'd16);
      for (int i = 0; i < 16; i++) begin
         out_read = 1;
         #1 chk("t1_drain", 64'(o32), 64'(i));
         tick();
      end
      out_read = 0;
      chk("t1_empty", 64'(empty32), 64'd1);
      chk("t1_words_out", 64'(wout32), 64'd16);
      chk("t1_no_unf_yet", 64'(unf32), 64'd0);
      out_read = 1;
      #1 chk("t1_empty_out", 64'(o32), 64'd0);
      tick();
      chk("t1_underflow", 64'(unf32), 64'd1);
      chk("t1_wout_hold", 64'(wout32), 64'd16);
      in_write = 1; in_data = 64'h55;
      tick();
      in_write = 0; out_read = 0;
      chk("t1_wr_rd_empty_lvl", 64'(lvl32), 64'd1);
      chk("t1_wr_rd_empty_win", 64'(win32), 64'd17);
      chk("t1_wr_rd_empty_wout", 64'(wout32), 64'd16);
      do_reset();

      // Test 2: generate mode counter across the wrap, table driven
      mode = 2'd1; pattern_sel = 2'd0; pattern_seed = 64'hFFFF_FFFE;
      pulse_reload();
      gv[0] = '{1'b1, 32'hFFFF_FFFE, 32'd1};
      gv[1] = '{1'b1, 32'hFFFF_FFFF, 32'd2};
      gv[2] = '{1'b1, 32'h0000_0000, 32'd3};
      gv[3] = '{1'b1, 32'h0000_0001, 32'd4};
      gv[4] = '{1'b0, 32'h0000_0002, 32'd4};
      for (int i = 0; i < 5; i++) begin
         out_read = gv[i].rd;
         #1 chk("t2_gen_word", 64'(o32), 64'(gv[i].exp_data));
         tick();
         chk("t2_words_out", 64'(wout32), 64'(gv[i].exp_wout));
      end
      out_read = 0;

      // Test 3: check mode, LFSR seed 0, one corrupted word at index 37
      mode = 2'd2; pattern_sel = 2'd1; pattern_seed = 64'd0;
      pulse_reload();
      for (int i = 0; i < 100; i++) begin
         in_write = 1;
         in_data = ref_word(2'd1, 64'd0, i, 32) ^ ((i == 37) ? 64'h10 : 64'd0);
         tick();
      end
      in_write = 0;
      chk("t3_err", 64'(err32), 64'd1);
      chk("t3_fei", 64'(fei32), 64'd37);
      chk("t3_words_in", 64'(win32), 64'd100);
      out_read = 1;
      #1 chk("t3_chk_out_zero", 64'(o32), 64'd0);
      tick();
      out_read = 0;
      chk("t3_chk_unf", 64'(unf32), 64'd1);
      mode = 2'd1;
      pulse_reload();
      chk("t3_lfsr_start", 64'(o32), 64'd1);
      for (int i = 0; i < 4; i++) begin
         out_read = 1;
         #1 chk("t3_lfsr_seq", 64'(o32), ref_word(2'd1, 64'd0, i, 32));
         tick();
      end
      out_read = 0;
      mode = 2'd0;
      do_reset();

      // Test 5: timer
      start_timer = 1;
      tick();
      start_timer = 0;
      chk("t5_on", 64'(ton32), 64'd1);
      chk("t5_first", clk32, 64'd1);
      repeat (99) tick();
      stop_timer = 1;
      tick();
      stop_timer = 0;
      chk("t5_count", clk32, 64'd100);
      chk("t5_off", 64'(ton32), 64'd0);
      repeat (3) tick();
      chk("t5_hold", clk32, 64'd100);
      start_timer = 1; stop_timer = 1;
      tick();
      start_timer = 0; stop_timer = 0;
      chk("t5_both", clk32, 64'd100);
      chk("t5_both_off", 64'(ton32), 64'd0);
      clear_stats = 1;
      tick();
      clear_stats = 0;
      chk("t5_clear", clk32, 64'd0);

      // Test 6: async reset with level 7
      for (int i = 0; i < 8; i++) begin
         in_write = 1; in_data = 64'(32'h100 + i);
         tick();
      end
      in_write = 0; out_read = 1; start_timer = 1;
      tick();
      out_read = 0; start_timer = 0;
      tick();
      chk("t6_level7", 64'(lvl32), 64'd7);
      #2 rst = 1'b1;
      #1;
      chk("t6_empty", 64'(empty32), 64'd1);
      chk("t6_out", 64'(o32), 64'd0);
      chk("t6_counts", 64'({win32, wout32}), 64'd0);
      chk("t6_clk", clk32, 64'd0);
      chk("t6_err", 64'(err32), 64'd0);
      chk("t6_fei", 64'(fei32), 64'hFFFF_FFFF);
      tick();
      rst = 1'b0;

      // Test 4: 64-bit walking-one loop+check at full occupancy
      mode = 2'd3; pattern_sel = 2'd2; pattern_seed = 64'hDEAD;
      pulse_reload();
      for (int i = 0; i < 16; i++) begin
         in_write = 1; in_data = ref_word(2'd2, 64'd0, i, 64);
         tick();
      end
      for (int i = 0; i < 114; i++) begin
         in_write = 1; out_read = 1;
         in_data = ref_word(2'd2, 64'd0, i + 16, 64);
         #1;
         if (i == 64) chk("t4_word64", o64, 64'd1);
         else         chk("t4_head", o64, ref_word(2'd2, 64'd0, i, 64));
         tick();
         chk("t4_level", 64'(lvl64), 64'd16);
      end
      in_write = 0;
      for (int i = 114; i < 130; i++) begin
         out_read = 1;
         #1 chk("t4_drain", o64, ref_word(2'd2, 64'd0, i, 64));
         tick();
      end
      out_read = 0;
      chk("t4_err", 64'(err64), 64'd0);
      chk("t4_win", 64'(win64), 64'd130);
      chk("t4_wout", 64'(wout64), 64'd130);
      chk("t4_empty", 64'(empty64), 64'd1);
      chk("t4_ovf", 64'(ovf64), 64'd0);

      // Randomized loop+check with LFSR against a queue model
      do_reset();
      seed = 64'($urandom);
      mode = 2'd3; pattern_sel = 2'd1; pattern_seed = seed;
      pulse_reload();
      q.delete();
      push_j = 0; k = 0; m_err = 0; m_first = -1; m_win = 0; m_wout = 0;
      m_ovf = 0; m_unf = 0;
      for (int c = 0; c < 300; c++) begin
         if (c < 150) begin
            w_ = ($urandom_range(0, 3) != 0);
            r_ = ($urandom_range(0, 2) == 0);
         end else begin
            w_ = ($urandom_range(0, 2) == 0);
            r_ = ($urandom_range(0, 3) != 0);
         end
         d = 32'(ref_word(2'd1, seed, push_j, 32));
         if ($urandom_range(0, 15) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
         in_write = w_; out_read = r_; in_data = 64'(d);
         #1 chk("rnd_head", 64'(o32), (q.size() > 0) ? 64'(q[0]) : 64'd0);
         pop_ok  = r_ && (q.size() > 0);
         push_ok = w_ && ((q.size() < 16) || pop_ok);
         if (w_ && !push_ok) m_ovf = 1;
         if (r_ && q.size() == 0) m_unf = 1;
         if (pop_ok) begin
            if (64'(q[0]) != ref_word(2'd1, seed, k, 32)) begin
               m_err++;
               if (m_first < 0) m_first = k;
            end
            k++;
            m_wout++;
            void'(q.pop_front());
         end
         if (push_ok) begin
            q.push_back(d);
            push_j++;
            m_win++;
         end
         tick();
         chk("rnd_level", 64'(lvl32), 64'(q.size()));
         chk("rnd_flags", 64'({ovf32, unf32}), 64'({m_ovf, m_unf}));
      end
      in_write = 0; out_read = 0;
      chk("rnd_err", 64'(err32), 64'(m_err));
      chk("rnd_fei", 64'(fei32), (m_first < 0) ? 64'hFFFF_FFFF : 64'(m_first));
      chk("rnd_win", 64'(win32), 64'(m_win));
      chk("rnd_wout", 64'(wout32), 64'(m_wout));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
